// File: rtl/tick_pkg.sv
// tick_pkg: shared command/adjust types and limits for the multi-channel tick generator
package tick_pkg;
  typedef enum logic [1:0] {OP_SET, OP_SLIP, OP_ADVANCE, OP_RESYNC} op_e;
  typedef enum logic [1:0] {ADJ_NONE, ADJ_PLUS, ADJ_MINUS} adj_e;
  localparam int MIN_PERIOD = 2;
  localparam int MIN_PW = 1;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_if.sv
// tick_if: configuration command bus with valid/ready handshake
interface tick_if #(parameter int NCH = 2, parameter int WIDTH = 27, parameter int PW_WIDTH = 8);
  import tick_pkg::*;
  localparam int CW = chan_w(NCH);
  logic cfg_valid;
  logic cfg_ready;
  logic [CW-1:0] cfg_chan;
  op_e cfg_op;
  logic [WIDTH-1:0] cfg_period;
  logic [PW_WIDTH-1:0] cfg_pw;
  modport master (output cfg_valid, cfg_chan, cfg_op, cfg_period, cfg_pw, input cfg_ready);
  modport slave (input cfg_valid, cfg_chan, cfg_op, cfg_period, cfg_pw, output cfg_ready);
endinterface

// File: rtl/tick_chan.sv
// tick_chan: one periodic strobe channel with shadow period, phase adjust, pulse stretcher and toggle
module tick_chan import tick_pkg::*; #(
  parameter int WIDTH = 27,
  parameter int PERIOD_RST = 124502500,
  parameter int PW_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cmd,
  input  op_e op,
  input  logic [WIDTH-1:0] period,
  input  logic [PW_WIDTH-1:0] pw_in,
  output logic tick,
  output logic pulse,
  output logic toggle,
  output logic busy
);
  logic [WIDTH-1:0] cnt, p, s;
  logic [PW_WIDTH-1:0] pw, pcnt, pcnt_n;
  logic [WIDTH:0] eff;
  logic fire;
  adj_e adj;
  // period never drops below MIN_PERIOD, so an advance at the floor leaves it unchanged
  always_comb begin
    eff = adj == ADJ_PLUS ? {1'b0, p} + 1'b1 :
          (adj == ADJ_MINUS && p > WIDTH'(MIN_PERIOD)) ? {1'b0, p} - 1'b1 : {1'b0, p};
    fire = en & (({1'b0, cnt} == eff - 1'b1) | (cmd & (op == OP_RESYNC)));
    pcnt_n = !en ? '0 : fire ? pw : pcnt - PW_WIDTH'(pcnt != '0);
  end
  assign busy = adj != ADJ_NONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p <= WIDTH'(PERIOD_RST);
      s <= WIDTH'(PERIOD_RST);
      pw <= PW_WIDTH'(MIN_PW);
      pcnt <= '0;
      adj <= ADJ_NONE;
      tick <= 1'b0;
      pulse <= 1'b0;
      toggle <= 1'b0;
    end else begin
      cnt <= (fire || !en) ? '0 : cnt + 1'b1;
      tick <= fire;
      pcnt <= pcnt_n;
      pulse <= pcnt_n != '0;
      toggle <= toggle ^ fire;
      if (fire) p <= s;
      // a new adjust accepted on a wrap applies to the period that wrap starts
      adj <= !en ? ADJ_NONE :
             (cmd && op == OP_SLIP) ? ADJ_PLUS :
             (cmd && op == OP_ADVANCE) ? ADJ_MINUS :
             fire ? ADJ_NONE : adj;
      if (cmd && op == OP_SET) begin
        s <= period < WIDTH'(MIN_PERIOD) ? WIDTH'(MIN_PERIOD) : period;
        pw <= pw_in < PW_WIDTH'(MIN_PW) ? PW_WIDTH'(MIN_PW) : pw_in;
      end
    end
  end
endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH independent programmable tick/pulse/toggle channels gated by PLL lock
module tick_gen import tick_pkg::*; #(
  parameter int NCH = 2,
  parameter int WIDTH = 27,
  parameter int PERIOD_RST = 124502500,
  parameter int PW_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked,
  tick_if.slave cfg,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pulse,
  output logic [NCH-1:0] toggle
);
  localparam int CW = chan_w(NCH);
  logic [NCH-1:0] busy, hit;
  logic [(1<<CW)-1:0] busy_x;
  // channel numbers beyond NCH read as idle so their commands are accepted and dropped
  always_comb begin
    busy_x = '0;
    busy_x[NCH-1:0] = busy;
  end
  assign cfg.cfg_ready = rst_n & locked &
    !((cfg.cfg_op == OP_SLIP || cfg.cfg_op == OP_ADVANCE) & busy_x[cfg.cfg_chan]);
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      assign hit[i] = cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_chan == CW'(i));
      tick_chan #(.WIDTH(WIDTH), .PERIOD_RST(PERIOD_RST), .PW_WIDTH(PW_WIDTH)) u_chan (
        .clk(clk),
        .rst_n(rst_n),
        .en(locked),
        .cmd(hit[i]),
        .op(cfg.cfg_op),
        .period(cfg.cfg_period),
        .pw_in(cfg.cfg_pw),
        .tick(tick[i]),
        .pulse(pulse[i]),
        .toggle(toggle[i]),
        .busy(busy[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed stimulus with a tick scoreboard checked by an independent monitor
module tb_tick_gen;
  import tick_pkg::*;
  localparam int NCH = 2;
  localparam int WIDTH = 8;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b1;
  logic [NCH-1:0] tick, pulse, toggle;
  typedef struct {int cyc; logic tog;} exp_t;
  exp_t q[NCH][$];
  logic [NCH-1:0] tog_m = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  tick_if #(.NCH(NCH), .WIDTH(WIDTH), .PW_WIDTH(PW)) bus();
  tick_gen #(.NCH(NCH), .WIDTH(WIDTH), .PERIOD_RST(10), .PW_WIDTH(PW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .locked(locked),
    .cfg(bus),
    .tick(tick),
    .pulse(pulse),
    .toggle(toggle)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) if (rst_n) cyc++;
  initial begin
    #20000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask
  function automatic void expect_tick(input int ch, input int c);
    tog_m[ch] = ~tog_m[ch];
    q[ch].push_back('{c, tog_m[ch]});
  endfunction
  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n) begin
      @(negedge clk);
      if (++g > 5000) begin
        $display("FAIL wait for cyc %0d timed out", n);
        $fatal(1);
      end
    end
  endtask
  task automatic send(input int ch, input op_e op, input int per, input int pw, output int acc);
    int g = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_chan = 1'(ch);
    bus.cfg_op = op;
    bus.cfg_period = WIDTH'(per);
    bus.cfg_pw = PW'(pw);
    #1;
    while (!bus.cfg_ready) begin
      @(negedge clk);
      #1;
      if (++g > 200) begin
        $display("FAIL send ch%0d op %0d never accepted", ch, op);
        $fatal(1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.cfg_valid = 1'b0;
  endtask
  // monitor: every observed tick must match the next expected tick cycle and toggle level
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        while (q[c].size() > 0 && q[c][0].cyc < cyc) begin
          e = q[c].pop_front();
          check($sformatf("missed tick ch%0d", c), cyc, e.cyc);
        end
        if (tick[c]) begin
          if (q[c].size() == 0) check($sformatf("unexpected tick ch%0d", c), cyc, -1);
          else begin
            e = q[c].pop_front();
            check($sformatf("tick cycle ch%0d", c), cyc, e.cyc);
            check($sformatf("toggle ch%0d", c), int'(toggle[c]), int'(e.tog));
          end
        end
      end
    end
  end
  initial begin
    int acc;
    int ch0_t[] = '{10, 20, 30, 40, 50, 61, 70, 80, 90, 100, 120, 130, 140, 150};
    bus.cfg_valid = 1'b0;
    bus.cfg_chan = '0;
    bus.cfg_op = OP_SET;
    bus.cfg_period = '0;
    bus.cfg_pw = '0;
    foreach (ch0_t[k]) expect_tick(0, ch0_t[k]);
    for (int c = 10; c <= 40; c += 10) expect_tick(1, c);
    for (int c = 45; c <= 85; c += 5) expect_tick(1, c);
    for (int c = 87; c <= 105; c += 2) expect_tick(1, c);
    for (int c = 112; c <= 124; c += 2) expect_tick(1, c);
    for (int c = 125; c <= 151; c += 2) expect_tick(1, c);
    #12;
    check("reset tick", int'(tick), 0);
    check("reset pulse", int'(pulse), 0);
    check("reset toggle", int'(toggle), 0);
    check("reset cfg_ready", int'(bus.cfg_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready after reset", int'(bus.cfg_ready), 1);
    wait_cyc(32);
    send(1, OP_SET, 5, 3, acc);
    check("set ch1 accept", acc, 33);
    wait_cyc(40);
    check("pulse at tick 40", int'(pulse), 3);
    wait_cyc(42);
    check("pulse pw3 third cycle", int'(pulse), 2);
    wait_cyc(43);
    check("pulse pw3 ended", int'(pulse), 0);
    wait_cyc(51);
    send(0, OP_SLIP, 0, 0, acc);
    check("slip ch0 accept", acc, 52);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan = 1'b0;
    bus.cfg_op = OP_ADVANCE;
    #1;
    check("advance blocked by pending slip", int'(bus.cfg_ready), 0);
    send(0, OP_ADVANCE, 0, 0, acc);
    check("advance ch0 accept after wrap", acc, 62);
    wait_cyc(81);
    send(1, OP_SET, 0, 0, acc);
    check("set ch1 clamp accept", acc, 82);
    wait_cyc(87);
    send(1, OP_ADVANCE, 0, 0, acc);
    check("advance ch1 at floor accept", acc, 88);
    wait_cyc(89);
    check("pw0 clamped pulse high", int'(pulse[1]), 1);
    wait_cyc(90);
    check("pw0 clamped pulse low", int'(pulse[1]), 0);
    wait_cyc(106);
    locked = 1'b0;
    wait_cyc(108);
    check("unlocked cfg_ready", int'(bus.cfg_ready), 0);
    check("unlocked toggle held", int'(toggle), 2);
    check("unlocked pulse", int'(pulse), 0);
    wait_cyc(110);
    locked = 1'b1;
    wait_cyc(121);
    send(0, OP_SET, 10, 4, acc);
    check("set ch0 pw4 accept", acc, 122);
    wait_cyc(124);
    send(1, OP_RESYNC, 0, 0, acc);
    check("resync ch1 accept", acc, 125);
    wait_cyc(139);
    send(0, OP_RESYNC, 0, 0, acc);
    check("resync ch0 on wrap accept", acc, 140);
    wait_cyc(151);
    check("pulse before reset", int'(pulse), 3);
    check("tick before reset", int'(tick), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset tick", int'(tick), 0);
    check("async reset pulse", int'(pulse), 0);
    check("async reset toggle", int'(toggle), 0);
    check("async reset cfg_ready", int'(bus.cfg_ready), 0);
    for (int c = 0; c < NCH; c++) check($sformatf("ticks outstanding ch%0d", c), q[c].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel successor to the single-channel PLL-gated tick divider. It generates NCH independent periodic strobes from one PLL-derived clock. Each channel has a runtime-programmable period, a stretched pulse output and a toggle (LED) output. Single-cycle phase slip/advance commands allow steering a channel against an external reference. Sits between the PLL and the board-level tick/tock/LED outputs.

## Interface
- NCH, 2, number of channels (1..8)
- WIDTH, 27, period counter width
- PERIOD_RST, 124502500, period of every channel after reset (must fit WIDTH)
- PW_WIDTH, 8, pulse-width field width
- clk  in  1  PLL output clock
- rst_n  in  1  reset, asynchronous assert, active-low
- locked  in  1  PLL lock; all channels held while 0
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accepted when cfg_valid & cfg_ready at posedge
- cfg_chan  in  max(1,$clog2(NCH))  target channel; values ≥NCH are accepted and ignored
- cfg_op  in  2  00 SET, 01 SLIP, 10 ADVANCE, 11 RESYNC
- cfg_period  in  WIDTH  new period (SET only)
- cfg_pw  in  PW_WIDTH  new pulse width (SET only)
- tick  out  NCH  one-cycle strobe per period
- pulse  out  NCH  tick stretched to pw cycles
- toggle  out  NCH  inverts on every tick

## Operation
- Per channel: counter cnt, active period P, shadow period S, pulse width pw, pending adjust adj ∈ {NONE,+1,−1}.
- Effective period E = P+1 (adj=+1), max(P−1,2) (adj=−1), else P.
- locked=1: cnt increments. When cnt==E−1: cnt←0, tick←1, toggle inverts, P←S, adj←NONE, pulse counter←pw.
- locked=0: cnt←0, tick←0, pulse←0, toggle holds, adj←NONE; S/P/pw retained.
- SET: S←max(cfg_period,2); pw←max(cfg_pw,1). P is not updated until the next wrap.
- SLIP/ADVANCE: adj←+1/−1 and is consumed at the next wrap.
- RESYNC: cnt←0, P←S, adj←NONE. tick asserts in the following cycle.
- cfg_ready = rst_n & locked & !(op∈{SLIP,ADVANCE} & adj[cfg_chan]≠NONE). At most one outstanding adjust per channel.
- pulse is high while the pulse counter is nonzero. A tick during an active pulse reloads the counter (retrigger). If pw ≥ E, pulse stays high continuously.

## Timing
- Reset values: cnt 0, P=S=PERIOD_RST, pw 1, adj NONE, tick/pulse/toggle 0, cfg_ready 0.
- All outputs are registered, except cfg_ready (combinational from registered state and cfg_chan/cfg_op).
- First tick asserts exactly P cycles after the first posedge with locked=1 sampled. Subsequent ticks are every E cycles.
- pulse rises with tick and is high for exactly pw cycles (absent retrigger).
- A SET accepted on a channel's wrap cycle is not seen by that wrap. The new period takes effect one full period later.
- A RESYNC accepted on a wrap cycle wins: one tick only, then the period restarts from 0.
- locked falling mid-period discards the partial period. No tick is emitted for it.
- rst_n assertion mid-pulse drops all outputs asynchronously.

## Structure
- Package tick_pkg:
  - op_e enum (OP_SET, OP_SLIP, OP_ADVANCE, OP_RESYNC)
  - adj_e enum
  - MIN_PERIOD=2
  - MIN_PW=1
- Sub-module tick_chan: one channel (counter, shadow, adjust, pulse stretcher, toggle). Generated NCH times.
- Top: command decode, cfg_ready logic, and the locked gate.

## Test plan
- Sim params NCH=2, WIDTH=8, PERIOD_RST=10. Release reset with locked=1 → ticks at cycles 10, 20, 30 on both channels; toggle alternates 1,0,1.
- SET ch1 period=5 pw=3 mid-period → current ch1 period still 10, then ticks every 5; pulse high 3 cycles each; ch0 unchanged.
- SLIP ch0, then ADVANCE ch0 → cfg_ready low for ADVANCE until the next ch0 wrap; resulting periods 11 then 9.
- SET period=0 → clamped to 2; ADVANCE at P=2 → period stays 2; pw=0 → 1-cycle pulse.
- Drop locked at cnt=6 for 4 cycles → no tick, toggle held, cfg_ready 0; first tick 10 cycles after relock.
- RESYNC on a wrap cycle plus async reset mid-pulse → a single tick; reset forces all outputs 0 immediately, with no clk edge needed.
